// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state, error-code and framing constants for the boot loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} loader_state_t;
  typedef logic [1:0] err_code_t;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam err_code_t ERR_NONE = 2'b00;
  localparam err_code_t ERR_LEN = 2'b01;
  localparam err_code_t ERR_CSUM = 2'b10;
  localparam err_code_t ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs bytes little-endian into a 32-bit word and pulses when one completes
module byte_word_packer (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic valid,
  input  logic [7:0] data,
  output logic [31:0] word,
  output logic word_done,
  output logic last_byte
);
  logic [1:0] idx;
  assign last_byte = idx == 2'd3;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      word <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= valid && last_byte;
      if (clear) idx <= '0;
      else if (valid) begin
        word[{idx, 3'b000} +: 8] <= data;
        idx <= idx + 2'd1;
      end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes it into instruction memory and
// holds the core in reset until a frame with a valid checksum has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = 16,
  parameter int ADDR_W = $clog2(IMEM_SIZE),
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [7:0] rx_data,
  input  logic rx_valid,
  output logic rx_ready,
  output logic imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic cpu_reset,
  output logic load_done,
  output logic load_error,
  output logic [1:0] err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  loader_state_t state, next_state;
  err_code_t err_next;
  logic xfer, busy, timeout, last_byte, sync;
  logic [ADDR_W-1:0] word_idx, last_idx;
  logic [7:0] csum;
  logic [TW-1:0] idle_cnt;
  assign xfer = rx_valid && rx_ready;
  assign sync = xfer && rx_data == SYNC_BYTE;
  assign busy = state inside {LEN, DATA, CSUM};
  assign timeout = idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign imem_addr = word_idx;
  byte_word_packer u_packer (
    .clk(clk),
    .reset_n(reset_n),
    .clear(state != DATA),
    .valid(xfer && state == DATA),
    .data(rx_data),
    .word(imem_wdata),
    .word_done(imem_we),
    .last_byte(last_byte)
  );
  always_comb begin
    next_state = state;
    err_next = err_code;
    case (state)
      IDLE, DONE: if (sync) next_state = LEN;
      LEN:
        if (xfer) begin
          next_state = (rx_data == 8'd0 || int'(rx_data) > IMEM_SIZE) ? ERROR : DATA;
          err_next = (next_state == ERROR) ? ERR_LEN : err_code;
        end
      DATA: if (xfer && last_byte && word_idx == last_idx) next_state = CSUM;
      CSUM:
        if (xfer) begin
          next_state = (rx_data == csum) ? DONE : ERROR;
          err_next = (rx_data == csum) ? err_code : ERR_CSUM;
        end
      ERROR:
        if (sync) begin
          next_state = LEN;
          err_next = ERR_NONE;
        end
      default: next_state = IDLE;
    endcase
    // An accepted byte always beats an expiring idle count
    if (busy && !xfer && timeout) begin
      next_state = ERROR;
      err_next = ERR_TIMEOUT;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rx_ready <= 1'b0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_error <= 1'b0;
      err_code <= ERR_NONE;
      word_idx <= '0;
      last_idx <= '0;
      csum <= '0;
      idle_cnt <= '0;
    end else begin
      state <= next_state;
      rx_ready <= 1'b1;
      cpu_reset <= next_state != DONE;
      load_done <= next_state == DONE;
      load_error <= next_state == ERROR;
      err_code <= err_next;
      idle_cnt <= (xfer || !busy) ? '0 : idle_cnt + TW'(1);
      if (state == LEN && next_state == DATA) begin
        word_idx <= '0;
        last_idx <= ADDR_W'(rx_data - 8'd1);
        csum <= '0;
      end else begin
        if (imem_we) word_idx <= word_idx + ADDR_W'(1);
        if (state == DATA && xfer) csum <= csum + rx_data;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks with randomized frames checked against a frame-level model
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, reset_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, imem_we, cpu_reset, load_done, load_error;
  logic [3:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0] err_code;
  int n_checks = 0, n_fail = 0, wr_count = 0;
  logic [31:0] dut_mem[16], ref_mem[16];
  logic [3:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic exp_done, exp_err;
  logic [1:0] exp_code;
  int exp_writes;

  imem_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Behaves as the downstream instruction memory
  always @(posedge clk)
    if (imem_we) begin
      dut_mem[imem_addr] = imem_wdata;
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_count++;
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input bq_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (gaps && i < q.size() - 1) idle($urandom_range(0, 3));
    end
  endtask

  function automatic bq_t make_frame(input int n, input bit bad_csum, input int garbage);
    bq_t q;
    logic [7:0] s = 8'h00, b;
    repeat (garbage) begin
      do b = 8'($urandom); while (b == 8'hA5);
      q.push_back(b);
    end
    q.push_back(8'hA5);
    q.push_back(8'(n));
    if (n >= 1 && n <= 16) begin
      repeat (4 * n) begin
        b = 8'($urandom);
        s += b;
        q.push_back(b);
      end
      q.push_back(bad_csum ? s + 8'd1 : s);
    end
    return q;
  endfunction

  // Frame-level reference: skip to the marker, then apply length, payload and sum rules
  task automatic model_frame(input bq_t q);
    int i = 0, n;
    logic [7:0] s = 8'h00;
    while (q[i] != 8'hA5) i++;
    n = q[i+1];
    i += 2;
    if (n == 0 || n > 16) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b01; exp_writes = 0;
      return;
    end
    for (int w = 0; w < n; w++) begin
      ref_mem[w] = {q[i+4*w+3], q[i+4*w+2], q[i+4*w+1], q[i+4*w]};
      for (int k = 0; k < 4; k++) s += q[i+4*w+k];
    end
    exp_writes = n;
    exp_done = q[i+4*n] == s;
    exp_err = !exp_done;
    exp_code = exp_done ? 2'b00 : 2'b10;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({rx_ready, imem_we, cpu_reset, load_done, load_error} !== 5'b00100) begin n_fail++; $display("FAIL reset_flags: got %b want 00100", {rx_ready, imem_we, cpu_reset, load_done, load_error}); end
    n_checks++; if ({imem_addr, imem_wdata, err_code} !== 38'd0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h err %b want zeros", imem_addr, imem_wdata, err_code); end
    reset_n = 1'b1;
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL release_rx_ready_early: got %b want 0", rx_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL release_rx_ready: rx_ready %b cpu_reset %b want 1 1", rx_ready, cpu_reset); end
  endtask

  task automatic test_good_frame;
    // 0x13+0x04+0x40+0x00+0x93+0x04+0xC0+0x00 = 0x1AE, so the checksum byte is 0xAE
    bq_t q = '{8'hA5, 8'h02, 8'h13, 8'h04, 8'h40, 8'h00, 8'h93, 8'h04, 8'hC0, 8'h00, 8'hAE};
    wr_addr_q.delete();
    wr_data_q.delete();
    model_frame(q);
    for (int i = 0; i < 10; i++) send_byte(q[i]);
    n_checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("FAIL good_before_csum: cpu_reset %b load_done %b want 1 0", cpu_reset, load_done); end
    send_byte(q[10]);
    n_checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1) begin n_fail++; $display("FAIL good_after_csum: cpu_reset %b load_done %b want 0 1", cpu_reset, load_done); end
    n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL good_write_count: got %0d want 2", wr_addr_q.size()); end
    else begin
      n_checks++; if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 32'h00400413) begin n_fail++; $display("FAIL good_word0: addr %0d data %h want 0 00400413", wr_addr_q[0], wr_data_q[0]); end
      n_checks++; if (wr_addr_q[1] !== 4'd1 || wr_data_q[1] !== 32'h00C00493) begin n_fail++; $display("FAIL good_word1: addr %0d data %h want 1 00c00493", wr_addr_q[1], wr_data_q[1]); end
    end
    n_checks++; if (dut_mem[1] !== ref_mem[1] || dut_mem[0] !== ref_mem[0]) begin n_fail++; $display("FAIL good_model: mem %h %h want %h %h", dut_mem[0], dut_mem[1], ref_mem[0], ref_mem[1]); end
  endtask

  task automatic test_bad_csum;
    bq_t bad = '{8'hA5, 8'h02, 8'h13, 8'h04, 8'h40, 8'h00, 8'h93, 8'h04, 8'hC0, 8'h00, 8'hAF};
    bq_t good = '{8'hA5, 8'h02, 8'h13, 8'h04, 8'h40, 8'h00, 8'h93, 8'h04, 8'hC0, 8'h00, 8'hAE};
    int w0 = wr_count;
    model_frame(bad);
    send_stream(bad, 1'b0);
    n_checks++; if ({load_error, err_code, cpu_reset, load_done} !== {exp_err, exp_code, !exp_done, exp_done}) begin n_fail++; $display("FAIL bad_csum_status: err %b code %b cpu_reset %b done %b want 1 10 1 0", load_error, err_code, cpu_reset, load_done); end
    n_checks++; if (wr_count - w0 != exp_writes) begin n_fail++; $display("FAIL bad_csum_writes: got %0d want %0d", wr_count - w0, exp_writes); end
    model_frame(good);
    send_stream(good, 1'b1);
    n_checks++; if ({load_error, err_code, cpu_reset, load_done} !== 5'b00001) begin n_fail++; $display("FAIL resend_status: err %b code %b cpu_reset %b done %b want 0 00 0 1", load_error, err_code, cpu_reset, load_done); end
  endtask

  task automatic test_bad_len;
    int w0 = wr_count;
    send_byte(8'h00);
    send_byte(8'hFF);
    n_checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL garbage_effect: done %b cpu_reset %b want 1 0", load_done, cpu_reset); end
    send_byte(8'hA5);
    n_checks++; if (load_done !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reload_sync: done %b cpu_reset %b want 0 1", load_done, cpu_reset); end
    send_byte(8'h11);
    model_frame('{8'h00, 8'hFF, 8'hA5, 8'h11});
    n_checks++; if (load_error !== exp_err || err_code !== exp_code || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL bad_len_status: err %b code %b cpu_reset %b want 1 01 1", load_error, err_code, cpu_reset); end
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL bad_len_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_timeout;
    int w0 = wr_count;
    send_byte(8'hA5);
    n_checks++; if (load_error !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL error_clear: err %b code %b want 0 00", load_error, err_code); end
    send_byte(8'h02);
    send_byte(8'h13);
    send_byte(8'h04);
    idle(49);
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL timeout_early: err %b want 0 after 49 idle cycles", load_error); end
    idle(1);
    n_checks++; if (load_error !== 1'b1 || err_code !== 2'b11 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL timeout_status: err %b code %b cpu_reset %b want 1 11 1", load_error, err_code, cpu_reset); end
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL timeout_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_reload;
    bq_t q = make_frame(2, 1'b0, 0);
    model_frame(q);
    send_stream(q, 1'b1);
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload_first: done %b want 1", load_done); end
    q = make_frame(1, 1'b0, 0);
    model_frame(q);
    send_byte(q[0]);
    n_checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("FAIL reload_reset: cpu_reset %b done %b want 1 0", cpu_reset, load_done); end
    for (int i = 1; i < q.size(); i++) send_byte(q[i]);
    n_checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL reload_done: done %b cpu_reset %b want 1 0", load_done, cpu_reset); end
    n_checks++; if (dut_mem[0] !== ref_mem[0]) begin n_fail++; $display("FAIL reload_addr0: got %h want %h", dut_mem[0], ref_mem[0]); end
    n_checks++; if (dut_mem[1] !== ref_mem[1]) begin n_fail++; $display("FAIL reload_addr1: got %h want %h", dut_mem[1], ref_mem[1]); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int kind = $urandom_range(0, 7);
      int n = (kind == 7) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255)) : $urandom_range(1, 16);
      bq_t q = make_frame(n, kind == 6, $urandom_range(0, 2));
      int w0 = wr_count;
      model_frame(q);
      send_stream(q, 1'b1);
      n_checks++; if ({load_done, load_error, err_code, cpu_reset} !== {exp_done, exp_err, exp_code, !exp_done}) begin n_fail++; $display("FAIL random_status[%0d]: done %b err %b code %b cpu_reset %b want %b %b %b %b", it, load_done, load_error, err_code, cpu_reset, exp_done, exp_err, exp_code, !exp_done); end
      n_checks++; if (wr_count - w0 != exp_writes) begin n_fail++; $display("FAIL random_writes[%0d]: got %0d want %0d", it, wr_count - w0, exp_writes); end
      for (int a = 0; a < 16; a++) begin
        n_checks++; if (dut_mem[a] !== ref_mem[a]) begin n_fail++; $display("FAIL random_mem[%0d][%0d]: got %h want %h", it, a, dut_mem[a], ref_mem[a]); end
      end
    end
  endtask

  task automatic test_mid_reset;
    bq_t q = make_frame(1, 1'b0, 0);
    model_frame(q);
    send_stream(q, 1'b0);
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pre: cpu_reset %b want 0", cpu_reset); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({cpu_reset, rx_ready, load_done} !== 3'b100) begin n_fail++; $display("FAIL mid_reset_async: cpu_reset %b rx_ready %b done %b want 1 0 0", cpu_reset, rx_ready, load_done); end
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    q = make_frame(1, 1'b0, 0);
    for (int i = 0; i < 6; i++) send_byte(q[i]);
    n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pulse: imem_we %b want 1", imem_we); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({imem_we, rx_ready, cpu_reset} !== 3'b001) begin n_fail++; $display("FAIL mid_reset_we: imem_we %b rx_ready %b cpu_reset %b want 0 0 1", imem_we, rx_ready, cpu_reset); end
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (rx_ready !== 1'b1 || dut_mem[0] !== ref_mem[0]) begin n_fail++; $display("FAIL mid_reset_after: rx_ready %b mem0 %h want 1 %h", rx_ready, dut_mem[0], ref_mem[0]); end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      dut_mem[a] = 32'h0;
      ref_mem[a] = 32'h0;
    end
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_reload();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
